// File: rtl/fp_mult_pipelined_pkg.sv
`default_nettype none
// ============================================================================
// Package    : gpu_fp_pkg
// Description: Shared floating-point definitions for the GPU datapath:
//              operand/result class codes, exception flag bit positions and
//              width-generic packers for the canonical qNaN and infinity.
// Revision   : 1.0  initial release
// ============================================================================
package gpu_fp_pkg;

    typedef enum logic [1:0] {
        FP_CLASS_ZERO = 2'd0,   // zero or subnormal (flushed)
        FP_CLASS_NORM = 2'd1,
        FP_CLASS_INF  = 2'd2,
        FP_CLASS_NAN  = 2'd3
    } fp_class_e;

    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

    // Results are 64 bits wide; callers truncate to 1+exp_w+man_w bits.
    function automatic logic [63:0] fp_pack_inf(input logic sign, input int exp_w, input int man_w);
        logic [63:0] r;
        r = ((64'd1 << exp_w) - 64'd1) << man_w;
        r = r | ({63'd0, sign} << (exp_w + man_w));
        return r;
    endfunction

    function automatic logic [63:0] fp_pack_qnan(input int exp_w, input int man_w);
        return fp_pack_inf(1'b0, exp_w, man_w) | (64'd1 << (man_w - 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_mult_pipelined_if.sv
`default_nettype none
// ============================================================================
// Interface  : fp_mult_pipelined_if
// Description: Operand/result handshake bundle of the pipelined FP multiplier.
//              slave  : the multiplier (accepts operands, produces results)
//              master : the client (drives operands, consumes results)
//   i_Valid/o_Ready/i_Factor1/i_Factor2/i_Tag : operand side
//   o_Valid/i_Ready/o_Product/o_Tag/o_Flags   : result side
// Revision   : 1.0  initial release
// ============================================================================
interface fp_mult_pipelined_if #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int TAG_W = 4
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic             i_Valid;
    logic             o_Ready;
    logic [W-1:0]     i_Factor1;
    logic [W-1:0]     i_Factor2;
    logic [TAG_W-1:0] i_Tag;
    logic             o_Valid;
    logic             i_Ready;
    logic [W-1:0]     o_Product;
    logic [TAG_W-1:0] o_Tag;
    logic [3:0]       o_Flags;

    modport slave (
        input  i_Valid, i_Factor1, i_Factor2, i_Tag, i_Ready,
        output o_Ready, o_Valid, o_Product, o_Tag, o_Flags
    );

    modport master (
        output i_Valid, i_Factor1, i_Factor2, i_Tag, i_Ready,
        input  o_Ready, o_Valid, o_Product, o_Tag, o_Flags
    );
endinterface
`default_nettype wire

// File: rtl/fp_mult_pipelined_round_rne.sv
`default_nettype none
// ============================================================================
// Module     : fp_round_rne
// Description: Combinational round-to-nearest-even on a normalised mantissa.
//   i_man/i_guard/i_round/i_sticky : truncated mantissa and the bits below it
//   i_exp                          : signed exponent of the value
//   o_man/o_exp                    : rounded mantissa, exponent bumped on carry
//   o_inexact                      : any discarded bit was set
// Revision   : 1.0  initial release
// ============================================================================
module fp_round_rne #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  wire logic [MAN_W-1:0]        i_man,
    input  wire logic                    i_guard,
    input  wire logic                    i_round,
    input  wire logic                    i_sticky,
    input  wire logic signed [EXP_W+1:0] i_exp,
    output logic [MAN_W-1:0]             o_man,
    output logic signed [EXP_W+1:0]      o_exp,
    output logic                         o_inexact
);
    localparam int EW = EXP_W + 2;
    localparam logic signed [EW-1:0] C_ONE = EW'(1);

    logic           w_incr;
    logic [MAN_W:0] w_sum;

    always_comb begin
        // Round up above halfway, or exactly halfway when the lsb is odd.
        w_incr    = i_guard && (i_round || i_sticky || i_man[0]);
        w_sum     = {1'b0, i_man} + {{MAN_W{1'b0}}, w_incr};
        // A carry out leaves the stored mantissa at zero (1.11..1 -> 10.00..0).
        o_man     = w_sum[MAN_W-1:0];
        o_exp     = w_sum[MAN_W] ? (i_exp + C_ONE) : i_exp;
        o_inexact = i_guard | i_round | i_sticky;
    end
endmodule
`default_nettype wire

// File: rtl/fp_mult_pipelined.sv
`default_nettype none
// ============================================================================
// Module     : fp_mult_pipelined
// Description: Three-stage pipelined floating-point multiplier, 1 op/clk,
//              round-to-nearest-even, flush-to-zero, IEEE-style flags.
//   i_Clk     : clock, rising edge
//   i_Reset_n : asynchronous active-low reset
//   bus       : operand/result handshake (slave side), see fp_mult_pipelined_if
//   S1 unpack/classify/multiply, S2 normalise, S3 round/range-check/pack.
// Revision   : 1.0  initial release
// ============================================================================
module fp_mult_pipelined
    import gpu_fp_pkg::*;
#(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int TAG_W = 4
) (
    input wire logic           i_Clk,
    input wire logic           i_Reset_n,
    fp_mult_pipelined_if.slave bus
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int EW = EXP_W + 2;
    localparam int PW = 2 * (MAN_W + 1);
    localparam logic signed [EW-1:0] C_BIAS    = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] C_EXP_MAX = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] C_ONE     = EW'(1);
    localparam logic [W-1:0]         C_QNAN    = W'(fp_pack_qnan(EXP_W, MAN_W));
    localparam logic [W-1:0]         C_INF     = W'(fp_pack_inf(1'b0, EXP_W, MAN_W));

    function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
        fp_class_e c;
        c = FP_CLASS_NORM;
        if (e == '0)
            c = FP_CLASS_ZERO;
        else if (&e)
            c = (m == '0) ? FP_CLASS_INF : FP_CLASS_NAN;
        return c;
    endfunction

    // Stage 1 registers
    logic                 valid1_d, valid1_q, sign1_d, sign1_q;
    logic signed [EW-1:0] exp1_d, exp1_q;
    logic [PW-1:0]        prod1_d, prod1_q;
    fp_class_e            res1_d, res1_q;
    logic [TAG_W-1:0]     tag1_d, tag1_q;
    // Stage 2 registers
    logic                 valid2_d, valid2_q, sign2_d, sign2_q;
    logic signed [EW-1:0] exp2_d, exp2_q;
    logic [MAN_W-1:0]     man2_d, man2_q;
    logic                 g2_d, g2_q, r2_d, r2_q, s2_d, s2_q;
    fp_class_e            res2_d, res2_q;
    logic [TAG_W-1:0]     tag2_d, tag2_q;
    // Output registers
    logic                 o_valid_d, o_valid_q;
    logic [W-1:0]         product_d, product_q;
    logic [TAG_W-1:0]     tag_d, tag_q;
    logic [3:0]           flags_d, flags_q;

    logic                 w_adv;
    fp_class_e            w_cls_a, w_cls_b;
    logic [MAN_W-1:0]     w_man_r;
    logic signed [EW-1:0] w_exp_r;
    logic                 w_inexact;

    // Single enable for every stage: the only backpressure point is the output.
    assign w_adv       = !o_valid_q || bus.i_Ready;
    assign bus.o_Ready = w_adv;
    assign bus.o_Valid = o_valid_q;
    assign bus.o_Product = product_q;
    assign bus.o_Tag   = tag_q;
    assign bus.o_Flags = flags_q;

    fp_round_rne #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
        .i_man     (man2_q),
        .i_guard   (g2_q),
        .i_round   (r2_q),
        .i_sticky  (s2_q),
        .i_exp     (exp2_q),
        .o_man     (w_man_r),
        .o_exp     (w_exp_r),
        .o_inexact (w_inexact)
    );

    // S1: classify, resolve special result class, exponent sum, mantissa product.
    always_comb begin
        w_cls_a  = classify(bus.i_Factor1[W-2:MAN_W], bus.i_Factor1[MAN_W-1:0]);
        w_cls_b  = classify(bus.i_Factor2[W-2:MAN_W], bus.i_Factor2[MAN_W-1:0]);
        valid1_d = valid1_q;
        sign1_d  = sign1_q;
        exp1_d   = exp1_q;
        prod1_d  = prod1_q;
        res1_d   = res1_q;
        tag1_d   = tag1_q;
        if (w_adv) begin
            valid1_d = bus.i_Valid;
            tag1_d   = bus.i_Tag;
            sign1_d  = bus.i_Factor1[W-1] ^ bus.i_Factor2[W-1];
            exp1_d   = $signed({2'b00, bus.i_Factor1[W-2:MAN_W]})
                     + $signed({2'b00, bus.i_Factor2[W-2:MAN_W]}) - C_BIAS;
            prod1_d  = PW'({1'b1, bus.i_Factor1[MAN_W-1:0]}) * PW'({1'b1, bus.i_Factor2[MAN_W-1:0]});
            if (w_cls_a == FP_CLASS_NAN || w_cls_b == FP_CLASS_NAN ||
                (w_cls_a == FP_CLASS_INF && w_cls_b == FP_CLASS_ZERO) ||
                (w_cls_a == FP_CLASS_ZERO && w_cls_b == FP_CLASS_INF))
                res1_d = FP_CLASS_NAN;
            else if (w_cls_a == FP_CLASS_INF || w_cls_b == FP_CLASS_INF)
                res1_d = FP_CLASS_INF;
            else if (w_cls_a == FP_CLASS_ZERO || w_cls_b == FP_CLASS_ZERO)
                res1_d = FP_CLASS_ZERO;
            else
                res1_d = FP_CLASS_NORM;
        end
    end

    // S2: product of two [1,2) values lies in [1,4); renormalise to [1,2).
    always_comb begin
        valid2_d = valid2_q;
        sign2_d  = sign2_q;
        exp2_d   = exp2_q;
        man2_d   = man2_q;
        g2_d     = g2_q;
        r2_d     = r2_q;
        s2_d     = s2_q;
        res2_d   = res2_q;
        tag2_d   = tag2_q;
        if (w_adv) begin
            valid2_d = valid1_q;
            sign2_d  = sign1_q;
            res2_d   = res1_q;
            tag2_d   = tag1_q;
            if (prod1_q[PW-1]) begin
                exp2_d = exp1_q + C_ONE;
                man2_d = prod1_q[PW-2 -: MAN_W];
                g2_d   = prod1_q[MAN_W];
                r2_d   = prod1_q[MAN_W-1];
                s2_d   = |prod1_q[MAN_W-2:0];
            end else begin
                exp2_d = exp1_q;
                man2_d = prod1_q[PW-3 -: MAN_W];
                g2_d   = prod1_q[MAN_W-1];
                r2_d   = prod1_q[MAN_W-2];
                s2_d   = |prod1_q[MAN_W-3:0];
            end
        end
    end

    // S3: apply special-case priority, then range-check the rounded exponent.
    always_comb begin
        o_valid_d = o_valid_q;
        product_d = product_q;
        tag_d     = tag_q;
        flags_d   = flags_q;
        if (w_adv) begin
            o_valid_d = valid2_q;
            tag_d     = tag2_q;
            flags_d   = '0;
            case (res2_q)
                FP_CLASS_NAN: begin
                    product_d              = C_QNAN;
                    flags_d[FLAG_INVALID]  = 1'b1;
                end
                FP_CLASS_INF:  product_d = C_INF | {sign2_q, {(W-1){1'b0}}};
                FP_CLASS_ZERO: product_d = {sign2_q, {(W-1){1'b0}}};
                default: begin
                    if (w_exp_r >= C_EXP_MAX) begin
                        product_d               = C_INF | {sign2_q, {(W-1){1'b0}}};
                        flags_d[FLAG_OVERFLOW]  = 1'b1;
                        flags_d[FLAG_INEXACT]   = 1'b1;
                    end else if (w_exp_r[EW-1] || w_exp_r == '0) begin
                        product_d               = {sign2_q, {(W-1){1'b0}}};
                        flags_d[FLAG_UNDERFLOW] = 1'b1;
                        flags_d[FLAG_INEXACT]   = 1'b1;
                    end else begin
                        product_d               = {sign2_q, w_exp_r[EXP_W-1:0], w_man_r};
                        flags_d[FLAG_INEXACT]   = w_inexact;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            valid1_q  <= 1'b0;
            sign1_q   <= 1'b0;
            exp1_q    <= '0;
            prod1_q   <= '0;
            res1_q    <= FP_CLASS_ZERO;
            tag1_q    <= '0;
            valid2_q  <= 1'b0;
            sign2_q   <= 1'b0;
            exp2_q    <= '0;
            man2_q    <= '0;
            g2_q      <= 1'b0;
            r2_q      <= 1'b0;
            s2_q      <= 1'b0;
            res2_q    <= FP_CLASS_ZERO;
            tag2_q    <= '0;
            o_valid_q <= 1'b0;
            product_q <= '0;
            tag_q     <= '0;
            flags_q   <= '0;
        end else begin
            valid1_q  <= valid1_d;
            sign1_q   <= sign1_d;
            exp1_q    <= exp1_d;
            prod1_q   <= prod1_d;
            res1_q    <= res1_d;
            tag1_q    <= tag1_d;
            valid2_q  <= valid2_d;
            sign2_q   <= sign2_d;
            exp2_q    <= exp2_d;
            man2_q    <= man2_d;
            g2_q      <= g2_d;
            r2_q      <= r2_d;
            s2_q      <= s2_d;
            res2_q    <= res2_d;
            tag2_q    <= tag2_d;
            o_valid_q <= o_valid_d;
            product_q <= product_d;
            tag_q     <= tag_d;
            flags_q   <= flags_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fp_mult_pipelined.sv
`default_nettype none
// ============================================================================
// Module     : tb_fp_mult_pipelined
// Description: Self-checking bench for fp_mult_pipelined (EXP_W=5, MAN_W=10).
//              Expected results are queued as operands are sent; a monitor
//              queues every transferred result; each test task compares them.
// Revision   : 1.0  initial release
// ============================================================================
module tb_fp_mult_pipelined;
    localparam int EXP_W = 5;
    localparam int MAN_W = 10;
    localparam int TAG_W = 4;

    typedef struct packed {
        logic [15:0] product;
        logic [3:0]  flags;
        logic [3:0]  tag;
    } res_t;

    // Reference vectors with hand-derived results; flags = {inv, ovf, unf, inx}.
    localparam logic [15:0] VA [8] = '{16'h3E00, 16'h3C01, 16'h3C01, 16'h7BFF,
                                        16'h0400, 16'h8400, 16'h7C00, 16'hFC00};
    localparam logic [15:0] VB [8] = '{16'h4000, 16'h3E00, 16'h3C01, 16'h4000,
                                        16'h3800, 16'h3800, 16'h0000, 16'h4000};
    localparam logic [15:0] VP [8] = '{16'h4200, 16'h3E02, 16'h3C02, 16'h7C00,
                                        16'h0000, 16'h8000, 16'h7E00, 16'hFC00};
    localparam logic [3:0]  VF [8] = '{4'b0000, 4'b0001, 4'b0001, 4'b0101,
                                        4'b0011, 4'b0011, 4'b1000, 4'b0000};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    res_t exp_q[$];
    res_t obs_q[$];
    res_t mon_r;

    always #5 clk = ~clk;

    fp_mult_pipelined_if #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) bus ();

    fp_mult_pipelined #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) dut (
        .i_Clk     (clk),
        .i_Reset_n (rst_n),
        .bus       (bus)
    );

    // Inputs change only at negedge; sample 2 time units later, before the
    // next rising edge where the transfer actually happens.
    always begin
        @(negedge clk);
        #2;
        if (rst_n && bus.o_Valid && bus.i_Ready) begin
            mon_r.product = bus.o_Product;
            mon_r.flags   = bus.o_Flags;
            mon_r.tag     = bus.o_Tag;
            obs_q.push_back(mon_r);
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [3:0] tag,
                        input logic [15:0] ep, input logic [3:0] ef);
        res_t e;
        int   n;
        @(negedge clk);
        bus.i_Valid   = 1'b1;
        bus.i_Factor1 = a;
        bus.i_Factor2 = b;
        bus.i_Tag     = tag;
        #1;
        n = 0;
        while (!bus.o_Ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (!bus.o_Ready) begin
            failures++;
            $display("FAIL send_accept_timeout o_Ready=%b required=1", bus.o_Ready);
        end
        e.product = ep;
        e.flags   = ef;
        e.tag     = tag;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.i_Valid = 1'b0;
    endtask

    task automatic wait_obs(input int n, input int budget, output bit ok);
        int c;
        c = 0;
        while (obs_q.size() < n && c < budget) begin
            @(negedge clk);
            #3;
            c++;
        end
        ok = (obs_q.size() >= n);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.o_Valid !== 1'b0) begin failures++; $display("FAIL reset_o_valid got=%b want=0", bus.o_Valid); end
        checks++; if (bus.o_Product !== 16'h0) begin failures++; $display("FAIL reset_o_product got=%h want=0000", bus.o_Product); end
        checks++; if (bus.o_Tag !== 4'h0) begin failures++; $display("FAIL reset_o_tag got=%h want=0", bus.o_Tag); end
        checks++; if (bus.o_Flags !== 4'h0) begin failures++; $display("FAIL reset_o_flags got=%b want=0000", bus.o_Flags); end
        rst_n = 1'b1;
        #1;
        checks++; if (bus.o_Ready !== 1'b1) begin failures++; $display("FAIL reset_o_ready got=%b want=1", bus.o_Ready); end
    endtask

    task automatic test_latency();
        int n;
        @(negedge clk);
        bus.i_Valid   = 1'b1;
        bus.i_Factor1 = VA[0];
        bus.i_Factor2 = VB[0];
        bus.i_Tag     = 4'h5;
        n = 0;
        // Count rising edges, the accepting edge being the first.
        while (n < 10) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) bus.i_Valid = 1'b0;
            if (bus.o_Valid) break;
        end
        checks++; if (n != 3) begin failures++; $display("FAIL latency got=%0d want=3", n); end
        checks++; if (bus.o_Product !== VP[0]) begin failures++; $display("FAIL latency_product got=%h want=%h", bus.o_Product, VP[0]); end
        checks++; if (bus.o_Flags !== VF[0]) begin failures++; $display("FAIL latency_flags got=%b want=%b", bus.o_Flags, VF[0]); end
        checks++; if (bus.o_Tag !== 4'h5) begin failures++; $display("FAIL latency_tag got=%h want=5", bus.o_Tag); end
        repeat (3) @(negedge clk);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_rounding();
        res_t e, o;
        bit   ok;
        send(VA[1], VB[1], 4'h1, VP[1], VF[1]);
        send(VA[2], VB[2], 4'h2, VP[2], VF[2]);
        idle();
        wait_obs(exp_q.size(), 20, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rounding_timeout got=%0d want=%0d results", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL rounding got=%h/%b/%h want=%h/%b/%h", o.product, o.flags, o.tag, e.product, e.flags, e.tag); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_range();
        res_t e, o;
        bit   ok;
        for (int i = 3; i <= 5; i++) send(VA[i], VB[i], 4'(i), VP[i], VF[i]);
        idle();
        wait_obs(exp_q.size(), 20, ok);
        checks++; if (!ok) begin failures++; $display("FAIL range_timeout got=%0d want=%0d results", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL range got=%h/%b/%h want=%h/%b/%h", o.product, o.flags, o.tag, e.product, e.flags, e.tag); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_special();
        res_t e, o;
        bit   ok;
        send(VA[6], VB[6], 4'h6, VP[6], VF[6]);
        send(VA[7], VB[7], 4'h7, VP[7], VF[7]);
        send(16'h7E01, 16'h3C00, 4'h8, 16'h7E00, 4'b1000);
        idle();
        wait_obs(exp_q.size(), 20, ok);
        checks++; if (!ok) begin failures++; $display("FAIL special_timeout got=%0d want=%0d results", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL special got=%h/%b/%h want=%h/%b/%h", o.product, o.flags, o.tag, e.product, e.flags, e.tag); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_back_to_back();
        res_t        e, o;
        bit          ok;
        logic [15:0] held;
        logic        held_v;
        held   = '0;
        held_v = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) send(VA[i], VB[i], 4'(i), VP[i], VF[i]);
                idle();
            end
            begin
                repeat (4) @(negedge clk);
                bus.i_Ready = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    #2;
                    if (k == 0) begin
                        held   = bus.o_Product;
                        held_v = bus.o_Valid;
                    end else if (held_v) begin
                        checks++;
                        if (bus.o_Product !== held || bus.o_Valid !== 1'b1) begin
                            failures++;
                            $display("FAIL stall_stable got=%h/%b want=%h/1", bus.o_Product, bus.o_Valid, held);
                        end
                    end
                    @(negedge clk);
                end
                bus.i_Ready = 1'b1;
            end
        join
        wait_obs(8, 40, ok);
        repeat (5) @(negedge clk);
        #3;
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL b2b_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL b2b got=%h/%b/%h want=%h/%b/%h", o.product, o.flags, o.tag, e.product, e.flags, e.tag); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_in_flight();
        obs_q.delete();
        send(VA[0], VB[0], 4'h9, VP[0], VF[0]);
        send(VA[1], VB[1], 4'hA, VP[1], VF[1]);
        send(VA[2], VB[2], 4'hB, VP[2], VF[2]);
        // After this edge: first op at the output, second in S2, third in S1.
        @(posedge clk);
        #1;
        rst_n       = 1'b0;
        bus.i_Valid = 1'b0;
        #1;
        checks++; if (bus.o_Valid !== 1'b0) begin failures++; $display("FAIL midreset_o_valid got=%b want=0", bus.o_Valid); end
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        #3;
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL midreset_outputs got=%0d want=0", obs_q.size()); end
        checks++; if (bus.o_Valid !== 1'b0) begin failures++; $display("FAIL midreset_after got=%b want=0", bus.o_Valid); end
    endtask

    initial begin
        bus.i_Valid   = 1'b0;
        bus.i_Factor1 = '0;
        bus.i_Factor2 = '0;
        bus.i_Tag     = '0;
        bus.i_Ready   = 1'b1;
        test_reset();
        test_latency();
        test_rounding();
        test_range();
        test_special();
        test_back_to_back();
        test_reset_in_flight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end
endmodule
`default_nettype wire
